// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load requesters and the RegFile write-port arbiter,
// including the registered RegFile write port driven by the arbiter.
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) ();
   logic              alu_req;
   logic [ADDR_W-1:0] alu_reg;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ack;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_reg;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ack;
   logic              reg_write;
   logic [ADDR_W-1:0] writeReg;
   logic [DATA_W-1:0] write_data;

   modport master (
      output alu_req, alu_reg, alu_data, mem_req, mem_reg, mem_data,
      input  alu_ack, mem_ack, reg_write, writeReg, write_data
   );

   modport slave (
      input  alu_req, alu_reg, alu_data, mem_req, mem_reg, mem_data,
      output alu_ack, mem_ack, reg_write, writeReg, write_data
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single RegFile write port (ALU vs. loads) with a per-register
// pending-write scoreboard for RAW hazard detection. Optional forwarding: REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter int PEND_W  = 2,
   parameter int R0_ZERO = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   regfile_wb_arbiter_if.slave wb,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   issue_reg,
   output logic                issue_ready,
   input  logic [ADDR_W-1:0]   readReg1,
   input  logic [ADDR_W-1:0]   readReg2,
   output logic                hazard1,
   output logic                hazard2
`ifdef REGFILE_WB_FWD_EN
   ,
   output logic                fwd1_valid,
   output logic                fwd2_valid,
   output logic [DATA_W-1:0]   fwd1_data,
   output logic [DATA_W-1:0]   fwd2_data
`endif
);

   localparam int                NREG      = 1 << ADDR_W;
   localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
   localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
   localparam logic [ADDR_W-1:0] REG_ZERO  = {ADDR_W{1'b0}};
`ifdef REGFILE_WB_FWD_EN
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
`endif

   typedef enum logic {
      RR_ALU = 1'b0,
      RR_MEM = 1'b1
   } rr_t;

   rr_t               rr_last_r;
   rr_t               rr_last_s;
   logic              grant_alu_s;
   logic              grant_mem_s;
   logic              wr_en_s;
   logic [ADDR_W-1:0] sel_reg_s;
   logic [DATA_W-1:0] sel_data_s;
   logic              reg_write_r;
   logic [ADDR_W-1:0] write_reg_r;
   logic [DATA_W-1:0] write_data_r;
   logic [PEND_W-1:0] pend_r [NREG];
   logic [NREG-1:0]   inc_s;
   logic [NREG-1:0]   dec_s;
   logic [PEND_W-1:0] pend1_s;
   logic [PEND_W-1:0] pend2_s;

   function automatic logic is_r0(input logic [ADDR_W-1:0] r);
      return (R0_ZERO != 0) && (r == REG_ZERO);
   endfunction

   // Round-robin grant, next round-robin state and selection of the winning writeback.
   always_comb begin
      grant_alu_s = 1'b0;
      grant_mem_s = 1'b0;
      wr_en_s     = 1'b0;
      rr_last_s   = rr_last_r;
      sel_reg_s   = wb.alu_reg;
      sel_data_s  = wb.alu_data;
      if (wb.alu_req && (!wb.mem_req || (rr_last_r == RR_MEM))) begin
         grant_alu_s = 1'b1;
         rr_last_s   = RR_ALU;
      end else if (wb.mem_req) begin
         grant_mem_s = 1'b1;
         rr_last_s   = RR_MEM;
         sel_reg_s   = wb.mem_reg;
         sel_data_s  = wb.mem_data;
      end else begin
         rr_last_s   = rr_last_r;
      end
      wr_en_s = (grant_alu_s || grant_mem_s) && !is_r0(sel_reg_s);
   end

   // Round-robin state register; MEM after reset so the ALU wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_r <= RR_MEM;
      end else begin
         rr_last_r <= rr_last_s;
      end
   end

   // Registered write stage; address/data hold when nothing is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_r  <= 1'b0;
         write_reg_r  <= REG_ZERO;
         write_data_r <= {DATA_W{1'b0}};
      end else begin
         reg_write_r <= wr_en_s;
         if (wr_en_s) begin
            write_reg_r  <= sel_reg_s;
            write_data_r <= sel_data_s;
         end
      end
   end

   assign wb.alu_ack    = grant_alu_s;
   assign wb.mem_ack    = grant_mem_s;
   assign wb.reg_write  = reg_write_r;
   assign wb.writeReg   = write_reg_r;
   assign wb.write_data = write_data_r;

   assign issue_ready = (pend_r[issue_reg] != PEND_MAX);

   // Per-register increment (accepted issue) and decrement (committed write) strobes.
   always_comb begin
      inc_s = {NREG{1'b0}};
      dec_s = {NREG{1'b0}};
      for (int r = 0; r < NREG; r++) begin
         if (issue_valid && issue_ready && (issue_reg == ADDR_W'(r)) && !is_r0(ADDR_W'(r))) begin
            inc_s[r] = 1'b1;
         end else begin
            inc_s[r] = 1'b0;
         end
         if (reg_write_r && (write_reg_r == ADDR_W'(r))) begin
            dec_s[r] = 1'b1;
         end else begin
            dec_s[r] = 1'b0;
         end
      end
   end

   // Pending-write counters; a decrement at zero is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            pend_r[r] <= PEND_ZERO;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            case ({inc_s[r], dec_s[r]})
               2'b10:   pend_r[r] <= pend_r[r] + PEND_W'(1);
               2'b01:   pend_r[r] <= (pend_r[r] != PEND_ZERO) ? pend_r[r] - PEND_W'(1) : PEND_ZERO;
               default: pend_r[r] <= pend_r[r];
            endcase
         end
      end
   end

   // Hazard (and optional forwarding) outputs for the two decode read ports.
   always_comb begin
      pend1_s = pend_r[readReg1];
      pend2_s = pend_r[readReg2];
      hazard1 = 1'b0;
      hazard2 = 1'b0;
`ifdef REGFILE_WB_FWD_EN
      fwd1_valid = reg_write_r && (write_reg_r == readReg1) && !is_r0(readReg1);
      fwd2_valid = reg_write_r && (write_reg_r == readReg2) && !is_r0(readReg2);
      fwd1_data  = write_data_r;
      fwd2_data  = write_data_r;
      hazard1 = (pend1_s != PEND_ZERO) && !is_r0(readReg1) && !((pend1_s == PEND_ONE) && fwd1_valid);
      hazard2 = (pend2_s != PEND_ZERO) && !is_r0(readReg2) && !((pend2_s == PEND_ONE) && fwd2_valid);
`else
      hazard1 = (pend1_s != PEND_ZERO) && !is_r0(readReg1);
      hazard2 = (pend2_s != PEND_ZERO) && !is_r0(readReg2);
`endif
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, directed corner sequences and
// randomized traffic against a behavioural model of arbitration, write stage and scoreboard.
module tb_regfile_wb_arbiter;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int NREG   = 8;
   localparam int PMAX   = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_reg;
   logic              issue_ready;
   logic [ADDR_W-1:0] readReg1;
   logic [ADDR_W-1:0] readReg2;
   logic              hazard1;
   logic              hazard2;
`ifdef REGFILE_WB_FWD_EN
   logic              fwd1_valid;
   logic              fwd2_valid;
   logic [DATA_W-1:0] fwd1_data;
   logic [DATA_W-1:0] fwd2_data;
`endif

   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

   regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PEND_W(2), .R0_ZERO(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb          (wb),
      .issue_valid (issue_valid),
      .issue_reg   (issue_reg),
      .issue_ready (issue_ready),
      .readReg1    (readReg1),
      .readReg2    (readReg2),
      .hazard1     (hazard1),
      .hazard2     (hazard2)
`ifdef REGFILE_WB_FWD_EN
      ,
      .fwd1_valid  (fwd1_valid),
      .fwd2_valid  (fwd2_valid),
      .fwd1_data   (fwd1_data),
      .fwd2_data   (fwd2_data)
`endif
   );

   typedef struct {
      logic              a_req;
      logic [ADDR_W-1:0] a_reg;
      logic [DATA_W-1:0] a_data;
      logic              m_req;
      logic [ADDR_W-1:0] m_reg;
      logic [DATA_W-1:0] m_data;
      logic              e_aack;
      logic              e_mack;
      logic              e_rw;
      logic [ADDR_W-1:0] e_wreg;
      logic [DATA_W-1:0] e_wdata;
   } vec_t;

   vec_t vecs [11];

   // Behavioural model: last winner (0 = ALU, 1 = MEM), write stage, pending counts.
   int   m_last;
   bit   m_rw;
   int   m_wreg;
   int   m_wdata;
   int   m_pend [NREG];
   int   n_pass;
   int   n_total;
   logic s_alu_ack;
   logic s_mem_ack;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_last = 1; m_rw = 1'b0; m_wreg = 0; m_wdata = 0;
      for (int r = 0; r < NREG; r++) m_pend[r] = 0;
   endtask

   function automatic bit m_fwd(input int r);
`ifdef REGFILE_WB_FWD_EN
      return m_rw && (m_wreg == r) && (r != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_hazard(input int r);
      if (r == 0) return 1'b0;
      if (m_pend[r] == 0) return 1'b0;
      if (m_pend[r] == 1 && m_fwd(r)) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: check combinational outputs, advance model, check registered outputs.
   task automatic step();
      bit ea, em, er, inc, dec;
      int sreg, sdata;
      #1;
      ea = wb.alu_req && (!wb.mem_req || m_last == 1);
      em = wb.mem_req && !ea;
      er = (m_pend[issue_reg] < PMAX);
      check("alu_ack", wb.alu_ack, ea);
      check("mem_ack", wb.mem_ack, em);
      check("issue_ready", issue_ready, er);
      check("hazard1", hazard1, m_hazard(readReg1));
      check("hazard2", hazard2, m_hazard(readReg2));
`ifdef REGFILE_WB_FWD_EN
      check("fwd1_valid", fwd1_valid, m_fwd(readReg1));
      check("fwd2_valid", fwd2_valid, m_fwd(readReg2));
      if (m_fwd(readReg1)) check("fwd1_data", fwd1_data, m_wdata);
      if (m_fwd(readReg2)) check("fwd2_data", fwd2_data, m_wdata);
`endif
      s_alu_ack = wb.alu_ack;
      s_mem_ack = wb.mem_ack;
      for (int r = 0; r < NREG; r++) begin
         inc = issue_valid && er && (issue_reg == r) && (r != 0);
         dec = m_rw && (m_wreg == r);
         if (inc && !dec) m_pend[r]++;
         else if (dec && !inc && m_pend[r] > 0) m_pend[r]--;
      end
      m_rw = 1'b0;
      if (ea || em) begin
         sreg   = ea ? int'(wb.alu_reg) : int'(wb.mem_reg);
         sdata  = ea ? int'(wb.alu_data) : int'(wb.mem_data);
         m_last = ea ? 0 : 1;
         if (sreg != 0) begin
            m_rw = 1'b1; m_wreg = sreg; m_wdata = sdata;
         end
      end
      @(posedge clk);
      #1;
      check("reg_write", wb.reg_write, m_rw);
      check("writeReg", wb.writeReg, m_wreg);
      check("write_data", wb.write_data, m_wdata);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      wb.alu_req = 1'b0; wb.alu_reg = '0; wb.alu_data = '0;
      wb.mem_req = 1'b0; wb.mem_reg = '0; wb.mem_data = '0;
      issue_valid = 1'b0; issue_reg = '0; readReg1 = '0; readReg2 = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      s_alu_ack = 1'b0; s_mem_ack = 1'b0;
      idle_inputs();
      vecs[0]  = '{1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b1, 1'b0, 1'b1, 3'd1, 16'h1111};
      vecs[1]  = '{1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b1, 1'b1, 3'd2, 16'h2222};
      vecs[2]  = '{1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b1, 1'b0, 1'b1, 3'd1, 16'h1111};
      vecs[3]  = '{1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b1, 1'b1, 3'd2, 16'h2222};
      vecs[4]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h7777, 1'b0, 1'b1, 1'b1, 3'd7, 16'h7777};
      vecs[5]  = '{1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3, 16'h1234};
      vecs[6]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd3, 16'h1234};
      vecs[7]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'hDEAD, 1'b0, 1'b1, 1'b0, 3'd3, 16'h1234};
      vecs[8]  = '{1'b1, 3'd0, 16'hBEEF, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd3, 16'h1234};
      vecs[9]  = '{1'b1, 3'd6, 16'hBEEF, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd6, 16'hBEEF};
      vecs[10] = '{1'b1, 3'd5, 16'h0505, 1'b1, 3'd4, 16'h0404, 1'b0, 1'b1, 1'b1, 3'd4, 16'h0404};

      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("rst_reg_write", wb.reg_write, 1'b0);
      check("rst_writeReg", wb.writeReg, 0);
      check("rst_write_data", wb.write_data, 0);
      check("rst_issue_ready", issue_ready, 1'b1);
      check("rst_hazard1", hazard1, 1'b0);
      check("rst_hazard2", hazard2, 1'b0);
      rst_n = 1'b1;

      // Vector table, starting from the reset round-robin state.
      for (int i = 0; i < 11; i++) begin
         wb.alu_req = vecs[i].a_req; wb.alu_reg = vecs[i].a_reg; wb.alu_data = vecs[i].a_data;
         wb.mem_req = vecs[i].m_req; wb.mem_reg = vecs[i].m_reg; wb.mem_data = vecs[i].m_data;
         step();
         check($sformatf("vec%0d_alu_ack", i), s_alu_ack, vecs[i].e_aack);
         check($sformatf("vec%0d_mem_ack", i), s_mem_ack, vecs[i].e_mack);
         check($sformatf("vec%0d_reg_write", i), wb.reg_write, vecs[i].e_rw);
         check($sformatf("vec%0d_writeReg", i), wb.writeReg, vecs[i].e_wreg);
         check($sformatf("vec%0d_write_data", i), wb.write_data, vecs[i].e_wdata);
      end
      idle_inputs();
      step();

      // Fill r5 to the limit, then drain it with three writebacks.
      readReg1 = 3'd5; issue_valid = 1'b1; issue_reg = 3'd5;
      repeat (3) step();
      check("sb_full_ready", issue_ready, 1'b0);
      check("sb_full_hazard1", hazard1, 1'b1);
      step();
      issue_valid = 1'b0;
      wb.alu_req = 1'b1; wb.alu_reg = 3'd5;
      for (int k = 1; k <= 3; k++) begin
         wb.alu_data = 16'(16'h0A00 + k);
         step();
      end
`ifndef REGFILE_WB_FWD_EN
      check("sb_last_wb_hazard1", hazard1, 1'b1);
`endif
      wb.alu_req = 1'b0;
      step();
      check("sb_drained_hazard1", hazard1, 1'b0);
      check("sb_drained_ready", issue_ready, 1'b1);

      // Issue r4 in the same cycle a write to r4 commits.
      readReg2 = 3'd4; issue_valid = 1'b1; issue_reg = 3'd4;
      step();
      issue_valid = 1'b0; wb.alu_req = 1'b1; wb.alu_reg = 3'd4; wb.alu_data = 16'h4040;
      step();
      wb.alu_req = 1'b0; issue_valid = 1'b1;
      step();
      check("incdec_hazard2", hazard2, 1'b1);
      issue_valid = 1'b0; wb.alu_req = 1'b1;
      step();
      wb.alu_req = 1'b0;
      step();
      check("incdec_drained_hazard2", hazard2, 1'b0);

      // Register 0 is read-only.
      wb.mem_req = 1'b1; wb.mem_reg = 3'd0; wb.mem_data = 16'hDEAD;
      step();
      check("r0_mem_ack", s_mem_ack, 1'b1);
      check("r0_reg_write", wb.reg_write, 1'b0);
      wb.mem_req = 1'b0; issue_valid = 1'b1; issue_reg = 3'd0; readReg1 = 3'd0;
      repeat (4) step();
      check("r0_hazard1", hazard1, 1'b0);
      check("r0_issue_ready", issue_ready, 1'b1);
      issue_valid = 1'b0;

`ifdef REGFILE_WB_FWD_EN
      readReg2 = 3'd6; issue_valid = 1'b1; issue_reg = 3'd6;
      step();
      issue_valid = 1'b0; wb.alu_req = 1'b1; wb.alu_reg = 3'd6; wb.alu_data = 16'hBEEF;
      step();
      check("fwd2_valid_r6", fwd2_valid, 1'b1);
      check("fwd2_data_r6", fwd2_data, 16'hBEEF);
      check("fwd2_hazard2", hazard2, 1'b0);
      wb.alu_req = 1'b0;
      step();
`endif

      // Asynchronous reset with a write in flight and a pending register.
      idle_inputs();
      wb.alu_req = 1'b1; wb.alu_reg = 3'd3; wb.alu_data = 16'h4444;
      issue_valid = 1'b1; issue_reg = 3'd2; readReg1 = 3'd2; readReg2 = 3'd2;
      step();
      check("pre_rst_reg_write", wb.reg_write, 1'b1);
      check("pre_rst_hazard1", hazard1, 1'b1);
      wb.alu_req = 1'b0; issue_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_reg_write", wb.reg_write, 1'b0);
      check("arst_hazard1", hazard1, 1'b0);
      check("arst_hazard2", hazard2, 1'b0);
      check("arst_issue_ready", issue_ready, 1'b1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Randomized traffic; requesters hold their request until acknowledged.
      for (int c = 0; c < 400; c++) begin
         if (!(wb.alu_req && !s_alu_ack)) begin
            wb.alu_req = 1'($urandom_range(0, 1)); wb.alu_reg = 3'($urandom_range(0, 7));
            wb.alu_data = 16'($urandom);
         end
         if (!(wb.mem_req && !s_mem_ack)) begin
            wb.mem_req = 1'($urandom_range(0, 1)); wb.mem_reg = 3'($urandom_range(0, 7));
            wb.mem_data = 16'($urandom);
         end
         issue_valid = ($urandom_range(0, 2) == 0);
         issue_reg = 3'($urandom_range(0, 7));
         readReg1 = 3'($urandom_range(0, 7));
         readReg2 = 3'($urandom_range(0, 7));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
